// File: rtl/alsu_result_tx.sv
// alsu_result_tx: buffers 6-bit ALSU results in a small FIFO and sends each
// one as an 8-bit UART-style frame (start, 8 data bits LSB first, stop).
// Optional feature: define ALSU_RESULT_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (11-bit frame).
// Handshake: res_valid is a one-cycle strobe with no back-pressure; a result
// arriving while the FIFO is full (and no frame pop frees a slot that cycle)
// is dropped and recorded in the sticky overflow flag.
module alsu_result_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [5:0] res_data,
    input  logic       overflow_clr,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count,
    output logic       overflow
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ALSU_RESULT_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
`ifdef ALSU_RESULT_TX_PARITY_EN
    logic          parity;
`endif

    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;
    logic          bit_end;

    // A frame is started from IDLE, or chained directly off the last stop cycle.
    assign bit_end = (bit_cnt == LAST);
    assign pop  = (fifo_count != 5'd0) &&
                  ((state == IDLE) || ((state == STOP) && bit_end));
    assign push = res_valid && ((fifo_count != DEPTH_C) || pop);
    assign drop = res_valid && (fifo_count == DEPTH_C) && !pop;

    // FIFO storage; a pop and a push to the same slot read the old head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 5'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 5'd1;
            end
            // A drop wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer with registered tx/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
`ifdef ALSU_RESULT_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= {2'b00, mem[rd_ptr]};
`ifdef ALSU_RESULT_TX_PARITY_EN
                        parity  <= ^mem[rd_ptr];
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= 16'd0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
`ifdef ALSU_RESULT_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`ifdef ALSU_RESULT_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        state   <= STOP;
                        tx      <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        if (pop) begin
                            shreg  <= {2'b00, mem[rd_ptr]};
`ifdef ALSU_RESULT_TX_PARITY_EN
                            parity <= ^mem[rd_ptr];
`endif
                            state  <= START;
                            tx     <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx     <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
